// File: rtl/lab3_excess3_to_bcd_serial_pkg.sv
// Shared constants for the serial Excess-3 <-> BCD conversion path.
package lab3_excess3_to_bcd_serial_pkg;
  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  XS3_OFFSET = 4'b0011;
  localparam logic [3:0]  XS3_MIN    = 4'b0011;
  localparam logic [3:0]  XS3_MAX    = 4'b1100;
  localparam logic [3:0]  BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {BIT0 = 2'd0, BIT1 = 2'd1, BIT2 = 2'd2, BIT3 = 2'd3} bit_idx_e;
endpackage

// File: rtl/D_ff_AR.sv
// Single-bit flop with asynchronous active-high clear.
module D_ff_AR (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end
endmodule

// File: rtl/serial_sub_cell.sv
// One-bit serial subtractor cell: z = x - s - borrow_in.
module serial_sub_cell (
  input  logic x,
  input  logic s,
  input  logic borrow_in,
  output logic z,
  output logic borrow_out
);
  assign z          = x ^ s ^ borrow_in;
  assign borrow_out = (~x & (s | borrow_in)) | (s & borrow_in);
endmodule

// File: rtl/lab3_excess3_to_bcd_serial.sv
// Bit-serial Excess-3 to BCD decoder: subtracts 0011 LSB-first, Mealy z, parallel digit out.
module lab3_excess3_to_bcd_serial
  import lab3_excess3_to_bcd_serial_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               x,
  input  logic               en,
  output logic               z,
  output logic [DIGIT_W-1:0] bcd,
  output logic               digit_valid,
  output logic               err
);
  logic [1:0]         idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic [2:0]         partial_q, partial_d;
  logic [DIGIT_W-1:0] bcd_q, bcd_d;
  logic               err_q, err_d;
  logic               dv_q, dv_d;

  logic               s, borrow_in, z_cell, borrow_out, last_bit;
  logic [DIGIT_W-1:0] assembled;

  // State register: bit index and borrow chain.
  D_ff_AR u_borrow (.clk(clock), .rst(reset), .d(borrow_d), .q(borrow_q));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_idx
      D_ff_AR u_idx (.clk(clock), .rst(reset), .d(idx_d[gi]), .q(idx_q[gi]));
    end
  endgenerate

  // Next-state logic.
  always_comb begin
    idx_d    = idx_q;
    borrow_d = borrow_q;
    if (en) begin
      idx_d    = idx_q + 2'd1;
      borrow_d = borrow_out;
    end
  end

  // Output logic.
  always_comb begin
    z = en & z_cell;
  end

  // Subtrahend is the offset bit at the current position; the chain restarts at bit 0.
  always_comb begin
    s         = XS3_OFFSET[idx_q];
    borrow_in = (idx_q == BIT0) ? 1'b0 : borrow_q;
    last_bit  = en && (idx_q == BIT3);
    assembled = {z_cell, partial_q};
  end

  serial_sub_cell u_cell (
    .x          (x),
    .s          (s),
    .borrow_in  (borrow_in),
    .z          (z_cell),
    .borrow_out (borrow_out)
  );

  // Assembler and error check.
  always_comb begin
    partial_d = partial_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    dv_d      = last_bit;
    if (en && !last_bit) partial_d = {z_cell, partial_q[2:1]};
    if (last_bit) begin
      bcd_d = assembled;
      err_d = borrow_out | (assembled > BCD_MAX);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      partial_q <= '0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      partial_q <= partial_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      dv_q      <= dv_d;
    end
  end

  assign bcd         = bcd_q;
  assign err         = err_q;
  assign digit_valid = dv_q;
endmodule

// File: doc/lab3_excess3_to_bcd_serial.md
# lab3_excess3_to_bcd_serial

Bit-serial Excess-3 to BCD converter: accepts one Excess-3 digit per four enabled clocks, LSB first, on `x`, and emits the corresponding BCD bit on `z` in the same cycle as a Mealy output. Completed digits are also assembled into a parallel BCD register and flagged valid or invalid. It is the decode end of the Lab 3 serial code-conversion path and restores BCD from the serial Excess-3 stream.

## Interface
- No parameters; digit width is fixed at 4 bits.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `x`  in  1  serial Excess-3 data bit, LSB of each digit first.
- `en`  in  1  bit-enable; `x` is consumed on a rising edge only when `en`=1.
- `z`  out  1  serial BCD bit (combinational, Mealy) for the current `x`.
- `bcd`  out  4  last completed BCD digit, parallel.
- `digit_valid`  out  1  one-cycle pulse: `bcd`/`err` updated.
- `err`  out  1  last completed digit was not a legal Excess-3 code (legal range 0011..1100).

## Operation
- State: 2-bit bit index `idx` (0..3), 1-bit `borrow`, 3-bit partial shift register for `z` bits, 4-bit `bcd`, 1-bit `err`, 1-bit `digit_valid`.
- The datapath subtracts the constant 0011 serially. Subtrahend bit `s` = 1 for `idx` 0 and 1, and 0 for `idx` 2 and 3.
- Bit-cell equations:
  - `z` = `x` ^ `s` ^ `borrow_in`, where `borrow_in` = 0 at `idx`=0, else the `borrow` register.
  - `borrow_out` = (~`x` & (`s` | `borrow_in`)) | (`s` & `borrow_in`).
- On a clock edge with `en`=1:
  - `borrow` <= `borrow_out`.
  - `idx` <= `idx`+1, wrapping 3 -> 0.
  - At `idx` 0..2, `z` is shifted into the partial register.
  - At `idx`=3:
    - `bcd` <= {`z`, partial[2:0]}.
    - `err` <= `borrow_out` | (assembled value > 9).
    - `digit_valid` <= 1.
- On a clock edge with `en`=0: `idx`, `borrow` and the partial register hold, and `digit_valid` <= 0.
- `z` is computed whenever `en`=1 and is driven to 0 when `en`=0.
- `bcd` and `err` hold their values until the next digit completes.
- Illegal codes (0000, 0001, 0010, 1101, 1110, 1111) still produce the arithmetic result on `bcd` and `z`, with `err`=1.

## Timing
- Reset values: `idx`=0, `borrow`=0, partial register 0, `bcd`=0000, `err`=0, `digit_valid`=0. `z` follows its combinational equation (0 while `en`=0).
- `z` latency: 0 cycles (combinational from `x`, `en` and state).
- `bcd`, `err` and `digit_valid` update on the edge that samples the 4th bit. They are visible in the following cycle, and `digit_valid` is high for exactly one cycle.
- Back-to-back digits are supported with no gap cycles. A new digit's bit 0 may be sampled on the cycle immediately after bit 3.
- Stalls: `en` may drop at any bit position for any number of cycles without corrupting the digit.
- Reset mid-digit: the partial digit is discarded, no `digit_valid` is produced, and the next enabled bit is treated as bit 0.
- Reset asserted in the cycle where `digit_valid`=1 forces `digit_valid` to 0 immediately.

## Structure
- Shared package: `DIGIT_W`=4, `XS3_OFFSET`=4'b0011, `XS3_MIN`=4'b0011, `XS3_MAX`=4'b1100, `BCD_MAX`=4'd9.
- The team's existing async-reset flop `D_ff_AR` is instantiated for `borrow` and the `idx` bits.
- The bit-cell is one natural sub-module, `serial_sub_cell`:
  - inputs `x`, `s`, `borrow_in`; outputs `z`, `borrow_out`.
  - purely combinational, reusable for serial BCD arithmetic.
- The FSM, the assembler and the error check live in the top module.

## Test plan
- Digit 7: Excess-3 1010 sent LSB first (`x`=0,1,0,1, `en`=1).
  - `z`=1,1,1,0.
  - Next cycle: `bcd`=0111, `err`=0, `digit_valid`=1 for one cycle.
- Digits 0 then 9: 0011 then 1100 sent back-to-back.
  - `bcd`=0000 then 1001.
  - Two `digit_valid` pulses, four cycles apart; `err`=0 for both.
- Illegal codes:
  - 0010 gives `bcd`=1111 with `err`=1 (borrow out).
  - 1101 gives `bcd`=1010 with `err`=1 (result > 9).
- Stall: 1010 sent with `en`=0 for 3 cycles between bits 1 and 2.
  - `bcd`=0111 and `err`=0.
  - `digit_valid` occurs only after the 4th enabled bit.
  - `z`=0 during the stall cycles.
- Reset mid-digit: two bits of 1000 sent, then a 1-cycle `reset`, then a full 0100 sent.
  - No pulse for the aborted digit.
  - Then `bcd`=0001, `err`=0, and all outputs at reset values during reset.
- Exhaustive: all 16 4-bit codes streamed back-to-back.
  - `bcd` equals code minus 3, mod 16.
  - `err`=1 exactly for codes outside 3..12.
